// File: rtl/pipelined_cla_adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pipelined_cla_adder_pkg
// Brief  : Shared helpers for the pipelined carry-lookahead adder:
//          slice-width legality check and signed saturation limits.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package pipelined_cla_adder_pkg;

  // Lookahead slices are only built for these widths.
  function automatic bit group_legal(input int g);
    return (g == 2) || (g == 4) || (g == 8);
  endfunction

  // Largest signed value of a w-bit word (w <= 64), e.g. 0x7FFF for w = 16.
  function automatic logic [63:0] signed_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative signed value of a w-bit word (w <= 64), e.g. 0x8000 for w = 16.
  function automatic logic [63:0] signed_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_cla_adder_cla_slice.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cla_slice
// Brief  : Combinational GROUP-bit carry-lookahead slice. Every internal
//          carry is a flat sum-of-products of generate/propagate terms.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module cla_slice #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] i_a,
  input  logic [GROUP-1:0] i_b,
  input  logic             i_cin,
  output logic [GROUP-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_msb,
  output logic             o_p,
  output logic             o_g
);

  logic [GROUP-1:0] w_pb;
  logic [GROUP-1:0] w_gb;
  logic [GROUP:0]   w_c;
  logic             w_acc;
  logic             w_prod;
  logic             w_grp_g;

  assign w_pb = i_a ^ i_b;
  assign w_gb = i_a & i_b;

  // Expand c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin for every bit.
  always_comb begin
    w_c     = '0;
    w_c[0]  = i_cin;
    w_acc   = 1'b0;
    w_prod  = 1'b0;
    w_grp_g = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      w_acc  = w_gb[i];
      w_prod = w_pb[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_acc  = w_acc | (w_prod & w_gb[j]);
        w_prod = w_prod & w_pb[j];
      end
      if (i == GROUP - 1) w_grp_g = w_acc;
      w_c[i+1] = w_acc | (w_prod & i_cin);
    end
  end

  assign o_sum   = w_pb ^ w_c[GROUP-1:0];
  assign o_cout  = w_c[GROUP];
  assign o_c_msb = w_c[GROUP-1];
  assign o_p     = &w_pb;
  assign o_g     = w_grp_g;

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : pipelined_cla_adder
// Brief  : Elastic pipelined carry-lookahead adder/subtractor. One GROUP-bit
//          slice per stage, carry registered between stages, registered
//          result with carry/overflow/zero flags and optional saturation.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl,
  output logic             zero
);

  localparam int NSTAGE = WIDTH / GROUP;
  localparam logic [WIDTH-1:0] c_smax = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] c_smin = WIDTH'(signed_min(WIDTH));

  if (((WIDTH % GROUP) != 0) || !group_legal(GROUP)) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP, GROUP in {2,4,8}");
  end

  // Stage-k registers hold the operands, the carry into slice k and the
  // result bits already produced by slices 0..k-1. Operand bits below the
  // current slice have no readers and are trimmed by synthesis.
  logic [NSTAGE-1:0] r_v;
  logic [NSTAGE-1:0] r_c;
  logic [NSTAGE-1:0] r_z;
  logic [NSTAGE-1:0] r_sat;
  logic [WIDTH-1:0]  r_a [NSTAGE];
  logic [WIDTH-1:0]  r_b [NSTAGE];
  logic [WIDTH-1:0]  r_s [NSTAGE];

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovfl;
  logic              r_zero;

  logic [GROUP-1:0]  w_ssum [NSTAGE];
  logic              w_cout [NSTAGE];
  logic              w_cmsb [NSTAGE];
  logic              w_p    [NSTAGE];
  logic              w_g    [NSTAGE];

  logic              w_adv;
  logic [WIDTH-1:0]  w_raw;
  logic [WIDTH-1:0]  w_fin_sum;
  logic              w_fin_ovfl;
  logic              w_fin_zero;

  // The whole pipe moves as one; it only stalls when a held result is refused.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    cla_slice #(.GROUP(GROUP)) u_slice (
      .i_a     (r_a[k][k*GROUP +: GROUP]),
      .i_b     (r_b[k][k*GROUP +: GROUP]),
      .i_cin   (r_c[k]),
      .o_sum   (w_ssum[k]),
      .o_cout  (w_cout[k]),
      .o_c_msb (w_cmsb[k]),
      .o_p     (w_p[k]),
      .o_g     (w_g[k])
    );
  end

  // Assemble the final slice, derive flags from raw arithmetic, then clamp.
  always_comb begin
    w_raw = r_s[NSTAGE-1];
    w_raw[(NSTAGE-1)*GROUP +: GROUP] = w_ssum[NSTAGE-1];
    w_fin_ovfl = w_cmsb[NSTAGE-1] ^ w_cout[NSTAGE-1];
    w_fin_zero = r_z[NSTAGE-1] & (w_ssum[NSTAGE-1] == '0);
    w_fin_sum  = w_raw;
    if (r_sat[NSTAGE-1] && w_fin_ovfl) begin
      w_fin_sum = r_a[NSTAGE-1][WIDTH-1] ? c_smin : c_smax;
    end
  end

  // Capture operands, advance every stage and register the result together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v         <= '0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovfl      <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_adv) begin
      r_v[0]   <= in_valid;
      r_a[0]   <= a;
      r_b[0]   <= b ^ {WIDTH{sub}};
      r_c[0]   <= sub;
      r_z[0]   <= 1'b1;
      r_sat[0] <= sat;
      r_s[0]   <= '0;
      for (int k = 0; k < NSTAGE - 1; k++) begin
        r_v[k+1]   <= r_v[k];
        r_a[k+1]   <= r_a[k];
        r_b[k+1]   <= r_b[k];
        r_sat[k+1] <= r_sat[k];
        // Group-level lookahead carry handed to the next slice.
        r_c[k+1]   <= w_g[k] | (w_p[k] & r_c[k]);
        r_z[k+1]   <= r_z[k] & (w_ssum[k] == '0);
        r_s[k+1]   <= r_s[k];
        r_s[k+1][k*GROUP +: GROUP] <= w_ssum[k];
      end
      r_out_valid <= r_v[NSTAGE-1];
      r_sum       <= w_fin_sum;
      r_cout      <= w_cout[NSTAGE-1];
      r_ovfl      <= w_fin_ovfl;
      r_zero      <= w_fin_zero;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovfl      = r_ovfl;
  assign zero      = r_zero;

endmodule
`default_nettype wire
